// File: rtl/vga_pkg.sv
// Shared VGA/VRAM types: geometry constants, port-owner encoding, queued write entry.
package vga_pkg;
  localparam int VRAM_ADDR_W = 14;
  localparam int RGB_W       = 3;
  localparam int HRES        = 128;
  localparam int VRES        = 96;
  localparam int WR_ENT_W    = VRAM_ADDR_W + RGB_W;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_READ  = 2'd1,
    OWN_WRITE = 2'd2
  } owner_e;

  // One queued pixel write; addr is {row[6:0], col[6:0]}
  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [RGB_W-1:0]       data;
  } wr_req_t;
endpackage

// File: rtl/vram_write_fifo.sv
// Small synchronous FIFO holding pending VRAM pixel writes in arrival order.
module vram_write_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic [WR_ENT_W-1:0]       i_din,
  input  logic                      i_pop,
  output logic [WR_ENT_W-1:0]       o_dout,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  wr_req_t                r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [PTR_W:0]         r_level;
  logic                   w_push;
  logic                   w_pop;

  assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rptr];

  // A push into a full queue is only legal when the head leaves in the same cycle
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  // Entry storage needs no reset; the level/pointers define what is valid
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= wr_req_t'(i_din);
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM sharing: scan-out reads always win, pixel writes are queued
// and drained on cycles the display does not need the port.
module vram_access_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int VBLANK_ONLY = 0,
  parameter int CNT_W       = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_disp_active,
  input  logic                          i_vblank,
  input  logic [VRAM_ADDR_W-1:0]        i_disp_addr,
  output logic [RGB_W-1:0]              o_disp_rgb,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [VRAM_ADDR_W-1:0]        i_wr_addr,
  input  logic [RGB_W-1:0]              i_wr_data,
  output logic                          o_ram_en,
  output logic                          o_ram_we,
  output logic [VRAM_ADDR_W-1:0]        o_ram_addr,
  output logic [RGB_W-1:0]              o_ram_wdata,
  input  logic [RGB_W-1:0]              i_ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]              o_wr_done_cnt
);
  owner_e              r_owner;
  owner_e              w_grant;
  logic                r_rdy_en;
  logic [CNT_W-1:0]    r_done_cnt;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_drain_ok;
  wr_req_t             w_head;
  wr_req_t             w_din;

  assign w_din      = '{addr: i_wr_addr, data: i_wr_data};
  assign w_drain_ok = (VBLANK_ONLY == 0) || i_vblank;
  assign w_pop      = (w_grant == OWN_WRITE);
  // Ready stays low through reset and until the first edge after release
  assign o_wr_ready = r_rdy_en & (~w_full | w_pop);
  assign w_push     = i_wr_valid & o_wr_ready;

  vram_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  // Port grant: display read, else drain queue head, else idle; reset forces idle
  always_comb begin
    w_grant     = OWN_IDLE;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (!i_reset) begin
      w_grant = OWN_IDLE;
    end else if (i_disp_active) begin
      w_grant    = OWN_READ;
      o_ram_en   = 1'b1;
      o_ram_addr = i_disp_addr;
    end else if (!w_empty && w_drain_ok) begin
      w_grant     = OWN_WRITE;
      o_ram_en    = 1'b1;
      o_ram_we    = 1'b1;
      o_ram_addr  = w_head.addr;
      o_ram_wdata = w_head.data;
    end
  end

  // Owner of the port last cycle decides whether ram_rdata is a pixel this cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_owner <= OWN_IDLE;
    else          r_owner <= w_grant;
  end

  // Write-side enable and completion counter
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rdy_en   <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_pop) r_done_cnt <= r_done_cnt + 1'b1;
    end
  end

  assign o_disp_rgb    = (r_owner == OWN_READ) ? i_ram_rdata : '0;
  assign o_wr_done_cnt = r_done_cnt;
endmodule

// File: tb/tb_vram_access_arbiter.sv
// Two arbiters (drain-any-idle and vblank-only) share stimulus; each is checked
// every cycle against a queue/array reference model plus directed spot checks.
module tb_vram_access_arbiter;
  localparam int FD = 4;
  localparam int CW = 16;
  localparam int LW = 3;

  typedef struct packed {
    logic [13:0] a;
    logic [2:0]  d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, disp, vblank, wr_valid, pre;
  logic [13:0] disp_addr, wr_addr;
  logic [2:0]  wr_data;
  logic [1:0][2:0]    rgb, ram_wdata, ram_rdata;
  logic [1:0]         wr_ready, ram_en, ram_we;
  logic [1:0][13:0]   ram_addr;
  logic [1:0][LW-1:0] level;
  logic [1:0][CW-1:0] cnt_o;

  vram_access_arbiter #(.FIFO_DEPTH(FD), .VBLANK_ONLY(0), .CNT_W(CW)) u0 (
    .i_clk(clk), .i_reset(rst_n), .i_disp_active(disp), .i_vblank(vblank),
    .i_disp_addr(disp_addr), .o_disp_rgb(rgb[0]), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready[0]), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_ram_en(ram_en[0]), .o_ram_we(ram_we[0]), .o_ram_addr(ram_addr[0]),
    .o_ram_wdata(ram_wdata[0]), .i_ram_rdata(ram_rdata[0]),
    .o_fifo_level(level[0]), .o_wr_done_cnt(cnt_o[0]));

  vram_access_arbiter #(.FIFO_DEPTH(FD), .VBLANK_ONLY(1), .CNT_W(CW)) u1 (
    .i_clk(clk), .i_reset(rst_n), .i_disp_active(disp), .i_vblank(vblank),
    .i_disp_addr(disp_addr), .o_disp_rgb(rgb[1]), .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready[1]), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_ram_en(ram_en[1]), .o_ram_we(ram_we[1]), .o_ram_addr(ram_addr[1]),
    .o_ram_wdata(ram_wdata[1]), .i_ram_rdata(ram_rdata[1]),
    .o_fifo_level(level[1]), .o_wr_done_cnt(cnt_o[1]));

  // VRAM models: synchronous read, write on en&we; preload clears and seeds 0x105=5
  logic [2:0] vmem [2][16384];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pre) begin
        for (int a = 0; a < 16384; a++) vmem[k][a] <= 3'd0;
        vmem[k][14'h0105] <= 3'b101;
        ram_rdata[k] <= 3'd0;
      end else begin
        if (ram_en[k] & ram_we[k])  vmem[k][ram_addr[k]] <= ram_wdata[k];
        if (ram_en[k] & ~ram_we[k]) ram_rdata[k] <= vmem[k][ram_addr[k]];
      end
    end
  end

  // Reference model state
  ent_t       q [2][$];
  logic [2:0] ref_mem [2][16384];
  int         mcnt [2];
  int         gr [2];
  bit         rdy [2];
  bit         rdy_en, prev_rd;
  logic [13:0] prev_addr;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      mcnt[k] = 0;
      gr[k] = 0;
      rdy[k] = 0;
    end
    rdy_en = 0;
    prev_rd = 0;
    prev_addr = '0;
  endtask

  // Expected outputs for the current inputs, compared against both DUTs
  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int g;
      logic [13:0] ea;
      logic [2:0] ed, er;
      bit er_dy;
      g = 0; ea = '0; ed = '0; er = '0; er_dy = 0;
      if (rst_n) begin
        if (disp) g = 1;
        else if (q[k].size() > 0 && (k == 0 || vblank)) g = 2;
        if (g == 1) ea = disp_addr;
        if (g == 2) begin ea = q[k][0].a; ed = q[k][0].d; end
        er_dy = rdy_en && (q[k].size() < FD || g == 2);
        if (prev_rd) er = ref_mem[k][prev_addr];
      end
      gr[k] = g;
      rdy[k] = er_dy;
      chk("ram_en",    k, ram_en[k],    g != 0);
      chk("ram_we",    k, ram_we[k],    g == 2);
      chk("ram_addr",  k, ram_addr[k],  ea);
      chk("ram_wdata", k, ram_wdata[k], ed);
      chk("wr_ready",  k, wr_ready[k],  er_dy);
      chk("disp_rgb",  k, rgb[k],       er);
      chk("level",     k, level[k],     q[k].size());
      chk("done_cnt",  k, cnt_o[k],     mcnt[k] % 65536);
    end
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        ent_t e;
        if (gr[k] == 2) begin
          e = q[k].pop_front();
          ref_mem[k][e.a] = e.d;
          mcnt[k]++;
        end
        if (wr_valid && rdy[k]) q[k].push_back('{a: wr_addr, d: wr_data});
      end
      prev_rd = disp;
      prev_addr = disp_addr;
      rdy_en = 1;
    end else begin
      model_reset();
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16384; a++) ref_mem[k][a] = 3'd0;
      ref_mem[k][14'h0105] = 3'b101;
    end
    model_reset();
    rst_n = 0; pre = 1; disp = 0; vblank = 1; wr_valid = 0;
    disp_addr = '0; wr_addr = '0; wr_data = '0;

    // 1: reset held 3 cycles, then release
    repeat (3) step();
    chk("rst_ready", 0, wr_ready[0], 1'b0);
    rst_n = 1; pre = 0;
    step();
    #1 chk("ready_after_rel", 0, wr_ready[0], 1'b1);
    chk("level_after_rel", 1, level[1], 0);

    // 2: display read of seeded pixel, then idle
    disp = 1; disp_addr = 14'h0105;
    #1 chk("t2_en", 0, ram_en[0], 1'b1);
    chk("t2_we", 0, ram_we[0], 1'b0);
    step();
    disp = 0;
    #1 chk("t2_rgb", 0, rgb[0], 3'b101);
    step();
    #1 chk("t2_rgb_idle", 0, rgb[0], 3'b000);

    // 3: fill while display busy, then drain in order
    disp = 1; disp_addr = 14'h0010;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 14'(i); wr_data = 3'(i + 1);
      step();
    end
    wr_valid = 0;
    #1 chk("t3_level", 0, level[0], 4);
    chk("t3_ready", 0, wr_ready[0], 1'b0);
    chk("t3_no_we", 0, ram_we[0], 1'b0);
    step();
    disp = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_we", 0, ram_we[0], 1'b1);
      chk("t3_addr", 0, ram_addr[0], i);
      chk("t3_data", 0, ram_wdata[0], i + 1);
      step();
    end
    #1 chk("t3_cnt", 0, cnt_o[0], 4);
    chk("t3_level0", 0, level[0], 0);

    // 4: full queue with simultaneous push+pop, then toggled display
    disp = 1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 14'(16 + i); wr_data = 3'(i % 7 + 1);
      step();
    end
    disp = 0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_addr = 14'(20 + i); wr_data = 3'((i + 3) % 8);
      #1 chk("t4_level", 0, level[0], 4);
      chk("t4_ready", 0, wr_ready[0], 1'b1);
      step();
    end
    wr_valid = 0;
    for (int i = 0; i < 8; i++) begin
      disp = (i % 2 == 0); disp_addr = 14'(16 + i);
      step();
    end
    disp = 0;
    repeat (3) step();

    // 5: vblank-only drain waits for vblank
    vblank = 0; disp = 0;
    wr_valid = 1; wr_addr = 14'h0020; wr_data = 3'd6;
    step();
    wr_valid = 0;
    #1 chk("t5_we_any", 0, ram_we[0], 1'b1);
    chk("t5_we_vb", 1, ram_we[1], 1'b0);
    step();
    #1 chk("t5_hold", 1, ram_we[1], 1'b0);
    chk("t5_level", 1, level[1], 1);
    step();
    vblank = 1;
    #1 chk("t5_vb_we", 1, ram_we[1], 1'b1);
    chk("t5_vb_addr", 1, ram_addr[1], 14'h0020);
    step();

    // 6: reset mid-drain
    disp = 1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 14'(48 + i); wr_data = 3'(i);
      step();
    end
    wr_valid = 0; disp = 0;
    step();
    #1 chk("t6_level3", 0, level[0], 3);
    chk("t6_we_pre", 0, ram_we[0], 1'b1);
    rst_n = 0;
    #1 model_reset();
    compare_all();
    chk("t6_we_rst", 0, ram_we[0], 1'b0);
    chk("t6_level_rst", 0, level[0], 0);
    chk("t6_cnt_rst", 0, cnt_o[0], 0);
    repeat (2) step();
    rst_n = 1;
    repeat (2) step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      disp      = ($urandom_range(0, 1) == 1);
      vblank    = ($urandom_range(0, 2) != 0);
      wr_valid  = ($urandom_range(0, 2) != 0);
      wr_addr   = 14'($urandom_range(0, 15));
      wr_data   = 3'($urandom_range(0, 7));
      disp_addr = 14'($urandom_range(0, 15));
      step();
    end
    disp = 0; vblank = 1; wr_valid = 0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
